// File: rtl/fq_pkg.sv
// Shared types and defaults for the fetch queue: entry layout, NOP encoding,
// and default sizing.
package fq_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pca;
    logic [31:0] cia;
  } fq_entry_t;

  localparam logic [31:0] NOP_INSTR         = 32'h0;
  localparam int          DEFAULT_DEPTH     = 4;
  localparam int          DEFAULT_AF_MARGIN = 2;

endpackage

// File: rtl/fq_mem.sv
// Fetch queue storage: DEPTH entries, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module fq_mem
  import fq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output fq_entry_t     rdata
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode with throttle and sticky
// overflow flag. Define FETCH_QUEUE_BYPASS_EN for same-cycle empty-queue bypass.
module fetch_queue
  import fq_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_MARGIN = DEFAULT_AF_MARGIN
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   fetch_valid,
  input  logic [31:0]            Instr_PR,
  input  logic [31:0]            PCA_PR,
  input  logic [31:0]            CIA_PR,
  input  logic                   FLUSH,
  input  logic                   id_ready,
  output logic                   id_valid,
  output logic [31:0]            Instr_ID,
  output logic [31:0]            PCA_ID,
  output logic [31:0]            CIA_ID,
  output logic                   no_new_fetch,
  output logic [$clog2(DEPTH):0] fq_count,
  output logic                   overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          bypass_take;
  logic          wr_en;
  logic          rd_adv;
  int            free_slots;
  fq_entry_t     in_entry;
  fq_entry_t     head_entry;
  fq_entry_t     out_entry;

  assign full     = (fq_count == FULL_COUNT);
  assign empty    = (fq_count == '0);
  assign in_entry = '{instr: Instr_PR, pca: PCA_PR, cia: CIA_PR};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass   = empty & fetch_valid & !FLUSH & !RESET;
  assign id_valid = !empty | bypass;
`else
  assign bypass   = 1'b0;
  assign id_valid = !empty;
`endif

  assign pop  = id_valid & id_ready & !FLUSH;
  assign push = fetch_valid & !FLUSH & (!full | pop);

  // A bypassed entry consumed in the same cycle never touches storage or pointers.
  assign bypass_take = bypass & id_ready;
  assign wr_en       = push & !bypass_take;
  assign rd_adv      = pop & !bypass_take;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fq_count <= '0;
    end else if (FLUSH) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fq_count <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_adv})
        2'b10:   fq_count <= fq_count + CW'(1);
        2'b01:   fq_count <= fq_count - CW'(1);
        default: fq_count <= fq_count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                        overflow_err <= 1'b0;
    else if (fetch_valid & !FLUSH & full & !pop)      overflow_err <= 1'b1;
  end

  fq_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (CLK),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in_entry),
    .raddr (rd_ptr),
    .rdata (head_entry)
  );

  always_comb begin
    out_entry = '{instr: NOP_INSTR, pca: 32'h0, cia: 32'h0};
    if (bypass)      out_entry = in_entry;
    else if (!empty) out_entry = head_entry;
  end

  assign Instr_ID = out_entry.instr;
  assign PCA_ID   = out_entry.pca;
  assign CIA_ID   = out_entry.cia;

  assign free_slots   = DEPTH - int'(fq_count);
  assign no_new_fetch = !RESET && (free_slots <= AF_MARGIN);

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter AF_MARGIN, default 2, the number of free entries at or below which fetch is throttled.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port fetch_valid, input, 1 bit: the fetch stage presents a fetched entry this cycle.
REQ-006 SHALL have port Instr_PR, input, 32 bits: the fetched instruction word; 0 is a NOP.
REQ-007 SHALL have port PCA_PR, input, 32 bits: the next-PC value associated with the entry.
REQ-008 SHALL have port CIA_PR, input, 32 bits: the current instruction address.
REQ-009 SHALL have port FLUSH, input, 1 bit: taken branch or redirect; discards all queued entries.
REQ-010 SHALL have port id_ready, input, 1 bit: the decode stage accepts the head entry this cycle.
REQ-011 SHALL have port id_valid, output, 1 bit: the head entry is valid.
REQ-012 SHALL have ports Instr_ID, PCA_ID and CIA_ID, output, 32 bits each: the head entry fields.
REQ-013 SHALL have port no_new_fetch, output, 1 bit: throttles the fetch stage.
REQ-014 SHALL have port fq_count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-015 SHALL have port overflow_err, output, 1 bit: sticky flag set when a push is dropped.

Function
REQ-016 SHALL be a circular FIFO of {Instr, PCA, CIA} entries using read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-017 SHALL define push = fetch_valid & !FLUSH & (fq_count<DEPTH | pop).
REQ-018 SHALL define pop = id_valid & id_ready & !FLUSH.
REQ-019 SHALL update fq_count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop, including when full.
REQ-020 SHALL drive id_valid = (fq_count!=0), with the output fields taken combinationally from the entry at the read pointer.
REQ-021 SHALL drive Instr_ID, PCA_ID and CIA_ID to zero when the queue is empty.
REQ-022 SHALL give a push-to-id_valid latency of exactly 1 cycle into an empty queue (bypass disabled).
REQ-023 SHALL drive no_new_fetch = (DEPTH - fq_count) <= AF_MARGIN as a combinational function of the registered count.
REQ-024 SHALL, on FLUSH, reset both pointers and fq_count to 0 on the next edge, and drop any same-cycle push and pop (FLUSH has priority).
REQ-025 SHALL set overflow_err when fetch_valid & !FLUSH & fq_count==DEPTH & !pop; it SHALL be cleared only by RESET.
REQ-026 SHALL store NOP entries (Instr_PR==0) like any other entry, with no filtering.
REQ-027 SHALL hold the head entry and id_valid stable while id_valid & !id_ready & !FLUSH.

Reset
REQ-028 SHALL, while RESET is high, immediately force pointers, fq_count, overflow_err and id_valid to 0, force data outputs to 0 and force no_new_fetch to 0.
REQ-029 SHALL hold all state at its reset value while RESET is asserted mid-operation, with in-flight entries lost.
REQ-030 SHALL NOT require storage-array contents to be reset.

Configuration
REQ-031 SHALL, with macro FETCH_QUEUE_BYPASS_EN defined and the queue empty with fetch_valid & !FLUSH, drive id_valid=1 and the inputs straight to the outputs in the same cycle; if id_ready is also 1 the entry is consumed without being written.
REQ-032 SHALL, without FETCH_QUEUE_BYPASS_EN, keep a 1-cycle minimum latency and purely registered-state id_valid.

Structure
REQ-033 SHALL place the fq_entry_t struct (instr, pca, cia, 32 bits each), the NOP_INSTR constant (32'h0) and the default DEPTH/AF_MARGIN constants in shared package fq_pkg.
REQ-034 SHALL instantiate one sub-module, fq_mem: a DEPTH x fq_entry_t register array with one write port and one asynchronous read port, without reset.

Verification
REQ-035 SHALL verify fill: 4 pushes of CIA 0x100..0x10C with id_ready=0 -> fq_count=4, no_new_fetch=1 from count 2 onward, id_valid=1, CIA_ID=0x100.
REQ-036 SHALL verify overflow: full queue, fetch_valid=1, id_ready=0 -> fq_count stays 4, overflow_err=1 and it persists.
REQ-037 SHALL verify full push/pop: full queue with fetch_valid=1 and id_ready=1 -> count stays 4, order is preserved across pointer wrap, overflow_err=0.
REQ-038 SHALL verify flush: 3 entries queued, FLUSH=1 with fetch_valid=1 and id_ready=1 -> next cycle fq_count=0, id_valid=0, Instr_ID=0.
REQ-039 SHALL verify latency: empty queue, single push of Instr 0x8C220004 -> id_valid=1 one cycle later (same cycle with FETCH_QUEUE_BYPASS_EN).
REQ-040 SHALL verify reset: RESET asserted mid-stream with 2 entries -> all outputs 0 immediately; after release the first new push appears at the head.
